uart_rx_deser: RTL and testbench

Synthesizable UART receiver that deserializes the SoC's serial TX line (8N1, LSB first) into bytes and buffers them in a small FIFO with a valid/ready output. It sits directly downstream of the SoC top-level UART pin and serves both as the on-board loopback/monitor path on the Gowin FPGA and as the byte consumer in simulation benches. Start-bit validation, mid-bit sampling at 16x oversampling, and framing and overrun detection are done in hardware.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 95 +++++++++
 rtl/uart_rx_deser.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: receiver FSM state encoding
// and the oversampling/framing constants used by uart_rx_deser.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 7;
    localparam int DATA_BITS  = 8;

    // Last tick index within one bit period (sample point after realignment).
    localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO with a registered head output.
//
// Ports:
//   clock    in   sole clock, rising edge
//   resetn   in   asynchronous active-low reset (pointers, level, head -> 0)
//   push     in   write request; ignored when full unless a pop happens too
//   wr_data  in   WIDTH-bit write data
//   pop      in   read request; ignored when empty
//   rd_data  out  WIDTH-bit head entry, meaningful while empty=0
//   full     out  level == DEPTH
//   empty    out  level == 0
//   level    out  current occupancy, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic [AW:0]      count_after_pop;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands if the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    assign rd_ptr_next     = rd_ptr + AW'(do_pop);
    assign count_after_pop = count - (AW+1)'(do_pop);
    assign count_next      = count_after_pop + (AW+1)'(do_push);

    // The head register is loaded with what will be at the head after this
    // edge; when the FIFO is (or is becoming) empty the incoming word bypasses
    // the memory so it is visible one cycle after the push.
    always_comb begin
        head_next = '0;
        if (count_next != '0) begin
            if (count_after_pop == '0) begin
                head_next = wr_data;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            head_q <= head_next;
        end
    end

    assign rd_data = head_q;

endmodule

// File: rtl/uart_rx_deser.sv
// -----------------------------------------------------------------------------
// uart_rx_deser
// 8N1 UART receiver (LSB first, 16x oversampling, mid-bit sampling) feeding a
// small byte FIFO with a valid/ready consumer interface. Detects framing
// errors (stop bit low) and overruns (byte arrives while the FIFO is full).
//
// Parameters:
//   DIV         clocks per oversample tick (bit period = 16*DIV clocks), 2..4095
//   FIFO_DEPTH  byte entries, power of two, 2..64
//
// Ports:
//   clock       in   sole clock, rising edge
//   resetn      in   asynchronous active-low reset
//   rx          in   serial line, idle high, asynchronous to clock
//   rx_data     out  FIFO head byte, valid while rx_valid=1
//   rx_valid    out  FIFO non-empty
//   rx_ready    in   head consumed on rx_valid & rx_ready
//   frame_err   out  one-cycle pulse: stop bit sampled low
//   overrun     out  one-cycle pulse: received byte dropped, FIFO full
//   fifo_level  out  current FIFO occupancy
// -----------------------------------------------------------------------------
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int DIV        = 27,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [11:0] DIV_LAST = 12'(DIV - 1);
    localparam logic [3:0]  MID_CNT  = 4'(SAMPLE_MID);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    logic            rx_p0;
    logic            rx_p1;
    logic            rx_s;
    rx_state_t       state;
    logic [11:0]     div_cnt;
    logic            tick;
    logic [3:0]      sample_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            stop_sample;
    logic            push_req;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;

    // ---- stage p0/p1: two-flop synchronizer, idles high ----
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_s = rx_p1;

    // ---- oversample tick generator ----
    // Held at zero in IDLE so every frame starts a fresh tick phase from the
    // cycle the start bit is first seen.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
        end else if (state == IDLE || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 12'd1;
        end
    end

    assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

    assign stop_sample = (state == STOP) && tick && (sample_cnt == SAMPLE_LAST);
    assign push_req    = stop_sample && rx_s;
    assign pop         = rx_valid && rx_ready;

    // ---- receiver FSM, shifter and status pulses ----
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // A simultaneous pop frees the slot, so only a stalled full FIFO drops.
            overrun   <= push_req && fifo_full && !pop;

            case (state)
                IDLE: begin
                    sample_cnt <= '0;
                    bit_idx    <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        if (sample_cnt == MID_CNT) begin
                            // From here on, count 15 lands in the middle of each bit.
                            sample_cnt <= '0;
                            state      <= rx_s ? IDLE : DATA;
                        end else begin
                            sample_cnt <= sample_cnt + 4'd1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (sample_cnt == SAMPLE_LAST) begin
                            sample_cnt <= '0;
                            shreg      <= {rx_s, shreg[7:1]};
                            if (bit_idx == LAST_BIT) begin
                                bit_idx <= '0;
                                state   <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 4'd1;
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (sample_cnt == SAMPLE_LAST) begin
                            sample_cnt <= '0;
                            if (rx_s) begin
                                state <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_IDLE;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 4'd1;
                        end
                    end
                end

                WAIT_IDLE: begin
                    // A held-low line (break) reports one framing error only.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ---- byte FIFO ----
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .push    (push_req),
        .wr_data (shreg),
        .pop     (pop),
        .rd_data (rx_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deser
// Scoreboard bench for uart_rx_deser with DIV=4 (64 clocks per bit) and a
// 16-entry FIFO. Stimulus pushes expected bytes into a queue; a monitor pops
// and compares whenever the consumer accepts a byte.
// -----------------------------------------------------------------------------
module tb_uart_rx_deser;

    localparam int DIV      = 4;
    localparam int DEPTH    = 16;
    localparam int BIT_CLKS = 16 * DIV;
    localparam int LW       = $clog2(DEPTH) + 1;
    // Stop-bit sample edge measured from the edge after which the stop bit is
    // driven: 3 (sync + FSM) + DIV*(8 + 16*9) - 9*BIT_CLKS = 3 + 608 - 576.
    localparam int STOP_OFS = 3 + DIV * (8 + 16 * 9) - 9 * BIT_CLKS;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic            rx = 1'b1;
    logic            rx_ready = 1'b0;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            frame_err;
    logic            overrun;
    logic [LW-1:0]   fifo_level;

    int              vectors = 0;
    int              miscompares = 0;
    logic [7:0]      exp_q[$];
    int              fe_seen = 0;
    int              ov_seen = 0;
    logic            fe_prev = 1'b0;
    logic            ov_prev = 1'b0;

    uart_rx_deser #(
        .DIV        (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_level (fifo_level)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares accepted bytes against the scoreboard and tracks pulses.
    always @(negedge clock) begin
        if (!resetn) begin
            fe_prev = 1'b0;
            ov_prev = 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_byte: got 0x%02h, expected no byte", rx_data);
                end else begin
                    check("rx_data", rx_data, exp_q.pop_front());
                end
            end
            if (frame_err) begin
                fe_seen++;
                check("frame_err_width", fe_prev, 0);
            end
            if (overrun) begin
                ov_seen++;
                check("overrun_width", ov_prev, 0);
            end
            fe_prev = frame_err;
            ov_prev = overrun;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Send one 8N1 frame. stop_len is the stop-bit length in bit periods;
    // pop_at_stop pulses rx_ready exactly in the stop-sample cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input int stop_len, input bit pop_at_stop);
        rx = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(BIT_CLKS);
        end
        rx = stop_val;
        if (pop_at_stop) begin
            step(STOP_OFS - 1);
            rx_ready = 1'b1;
            step(1);
            rx_ready = 1'b0;
            step(BIT_CLKS - STOP_OFS);
        end else begin
            step(BIT_CLKS * stop_len);
        end
        rx = 1'b1;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            step(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        resetn = 1'b0;
        step(3);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        check("reset_fifo_level", fifo_level, 0);
        resetn = 1'b1;
        step(5);

        // Single byte with consumer always ready
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1, 1'b0);
        step(BIT_CLKS);
        wait_empty("a5_drained");
        check("a5_level", fifo_level, 0);
        check("a5_frame_err_count", fe_seen, 0);
        check("a5_overrun_count", ov_seen, 0);

        // Short low glitch on idle line is rejected
        rx = 1'b0;
        step(20);
        rx = 1'b1;
        step(4 * BIT_CLKS);
        check("glitch_level", fifo_level, 0);
        check("glitch_frame_err_count", fe_seen, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1, 1'b0);
        step(BIT_CLKS);
        wait_empty("glitch_3c_drained");

        // Stop bit held low for three bit periods: one framing error, no byte
        send_frame(8'h55, 1'b0, 3, 1'b0);
        step(2 * BIT_CLKS);
        check("break_frame_err_count", fe_seen, 1);
        check("break_level", fifo_level, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1, 1'b0);
        step(BIT_CLKS);
        wait_empty("break_3c_drained");

        // Fill the FIFO with the consumer stalled; the 17th byte overruns
        rx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1, 1'b0);
        end
        step(BIT_CLKS);
        check("full_level", fifo_level, 16);
        check("full_overrun_count", ov_seen, 1);
        rx_ready = 1'b1;
        wait_empty("full_drained");
        step(2);
        check("full_level_after_drain", fifo_level, 0);

        // Full FIFO: pop and push on the same edge -> no overrun
        rx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'h20 + i));
            send_frame(8'(8'h20 + i), 1'b1, 1, 1'b0);
        end
        step(4);
        check("pp_level_full", fifo_level, 16);
        exp_q.push_back(8'h30);
        send_frame(8'h30, 1'b1, 1, 1'b1);
        step(4);
        check("pp_level_after", fifo_level, 16);
        check("pp_overrun_count", ov_seen, 1);
        rx_ready = 1'b1;
        wait_empty("pp_drained");
        step(2);
        check("pp_level_after_drain", fifo_level, 0);

        // Reset in the middle of a frame discards FIFO contents and the partial byte
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b1, 1, 1'b0);
        step(5);
        check("rst_level_before", fifo_level, 1);
        rx = 1'b0;
        step(BIT_CLKS);
        rx = 1'b1;
        step(100);
        resetn = 1'b0;
        step(2);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        resetn = 1'b1;
        step(11 * BIT_CLKS);
        check("rst_level_idle", fifo_level, 0);
        rx_ready = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1, 1'b0);
        step(BIT_CLKS);
        wait_empty("rst_81_drained");

        check("final_frame_err_count", fe_seen, 1);
        check("final_overrun_count", ov_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
